// File: rtl/arc4_pkg.sv
// Shared types and default widths for the ARC4 scheduler and its s_mem port mux.
package arc4_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int KEY_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_GO,
    S_INIT_RUN,
    S_KSA_GO,
    S_KSA_RUN,
    S_PRGA_GO,
    S_PRGA_RUN,
    S_DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_INIT,
    G_KSA,
    G_PRGA
  } grant_t;

endpackage

// File: rtl/smem_port_mux.sv
// Routes the granted engine onto the shared s_mem port and flags writes from any other engine.
module smem_port_mux
  import arc4_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  grant_t          grant_i,
  input  logic [AW-1:0]   init_addr_i,
  input  logic [DW-1:0]   init_wrdata_i,
  input  logic            init_wren_i,
  input  logic [AW-1:0]   ksa_addr_i,
  input  logic [DW-1:0]   ksa_wrdata_i,
  input  logic            ksa_wren_i,
  input  logic [AW-1:0]   prga_addr_i,
  input  logic [DW-1:0]   prga_wrdata_i,
  input  logic            prga_wren_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wrdata_o,
  output logic            mem_wren_o,
  output logic            conflict_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    mem_addr_o   = '0;
    mem_wrdata_o = '0;
    mem_wren_o   = 1'b0;
    conflict_o   = init_wren_i | ksa_wren_i | prga_wren_i;
    case (grant_i)
      G_INIT: begin
        mem_addr_o   = init_addr_i;
        mem_wrdata_o = init_wrdata_i;
        mem_wren_o   = init_wren_i;
        conflict_o   = ksa_wren_i | prga_wren_i;
      end
      G_KSA: begin
        mem_addr_o   = ksa_addr_i;
        mem_wrdata_o = ksa_wrdata_i;
        mem_wren_o   = ksa_wren_i;
        conflict_o   = init_wren_i | prga_wren_i;
      end
      G_PRGA: begin
        mem_addr_o   = prga_addr_i;
        mem_wrdata_o = prga_wrdata_i;
        mem_wren_o   = prga_wren_i;
        conflict_o   = init_wren_i | ksa_wren_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// Sequences the init, ksa and prga engines over one s_mem port and owns write arbitration.
module arc4_sched #(
  parameter int ADDR_W = arc4_pkg::ADDR_W,
  parameter int DATA_W = arc4_pkg::DATA_W,
  parameter int KEY_W  = arc4_pkg::KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [KEY_W-1:0]  key,
  output logic              rdy,
  output logic              done,
  output logic              err,
  output logic [KEY_W-1:0]  key_out,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic              mem_wren
);

  import arc4_pkg::*;

  sched_state_t       state_q;
  grant_t             grant_q;
  logic               seen_busy_q;
  logic [KEY_W-1:0]   key_q;
  logic               done_q;
  logic               err_q;
  logic               eng_rdy;
  logic               conflict;

  // Ready of whichever engine currently holds the grant.
  always_comb begin
    eng_rdy = 1'b0;
    case (grant_q)
      G_INIT:  eng_rdy = init_rdy;
      G_KSA:   eng_rdy = ksa_rdy;
      G_PRGA:  eng_rdy = prga_rdy;
      default: eng_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      seen_busy_q <= 1'b0;
      key_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge state.
      if (conflict) err_q <= 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (en) begin
            key_q   <= key;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= G_INIT;
            state_q <= S_INIT_GO;
          end
        end
        S_INIT_GO: if (eng_rdy) begin
          seen_busy_q <= 1'b0;
          state_q     <= S_INIT_RUN;
        end
        S_INIT_RUN: begin
          if (!eng_rdy) seen_busy_q <= 1'b1;
          else if (seen_busy_q) begin
            grant_q <= G_KSA;
            state_q <= S_KSA_GO;
          end
        end
        S_KSA_GO: if (eng_rdy) begin
          seen_busy_q <= 1'b0;
          state_q     <= S_KSA_RUN;
        end
        S_KSA_RUN: begin
          if (!eng_rdy) seen_busy_q <= 1'b1;
          else if (seen_busy_q) begin
            grant_q <= G_PRGA;
            state_q <= S_PRGA_GO;
          end
        end
        S_PRGA_GO: if (eng_rdy) begin
          seen_busy_q <= 1'b0;
          state_q     <= S_PRGA_RUN;
        end
        S_PRGA_RUN: begin
          if (!eng_rdy) seen_busy_q <= 1'b1;
          else if (seen_busy_q) begin
            grant_q <= G_NONE;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          grant_q <= G_NONE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Start pulses are decoded from the registered state so they land in the GO cycle itself.
  assign init_en = (state_q == S_INIT_GO) && init_rdy;
  assign ksa_en  = (state_q == S_KSA_GO)  && ksa_rdy;
  assign prga_en = (state_q == S_PRGA_GO) && prga_rdy;

  assign rdy     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done    = done_q;
  assign err     = err_q;
  assign key_out = key_q;

  smem_port_mux #(
    .AW(ADDR_W),
    .DW(DATA_W)
  ) u_mux (
    .grant_i       (grant_q),
    .init_addr_i   (init_addr),
    .init_wrdata_i (init_wrdata),
    .init_wren_i   (init_wren),
    .ksa_addr_i    (ksa_addr),
    .ksa_wrdata_i  (ksa_wrdata),
    .ksa_wren_i    (ksa_wren),
    .prga_addr_i   (prga_addr),
    .prga_wrdata_i (prga_wrdata),
    .prga_wren_i   (prga_wren),
    .mem_addr_o    (mem_addr),
    .mem_wrdata_o  (mem_wrdata),
    .mem_wren_o    (mem_wren),
    .conflict_o    (conflict)
  );

endmodule

// File: tb/tb_arc4_sched.sv
// Bench for arc4_sched: stub engines with programmable busy time, an ownership-based reference model, scenario tasks.
module tb_arc4_sched;

  typedef int tri_t [3];

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] key;
  logic        rdy, done, err;
  logic [23:0] key_out;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, ksa_addr, prga_addr;
  logic [7:0]  init_wrdata, ksa_wrdata, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  mem_addr, mem_wrdata;
  logic        mem_wren;

  // Stub engine controls: busy length, rdy-high delay after en, forced not-ready, write injection.
  int          len [3];
  int          dly [3];
  bit          hold_low [3];
  bit          inj [3];
  logic [7:0]  inj_addr [3];
  logic [7:0]  inj_data [3];
  logic [7:0]  rnd_addr [3];
  logic [7:0]  rnd_data [3];
  bit          rnd_w [3];
  int          pre [3];
  int          busy [3];

  logic [2:0]  eng_en;
  logic [2:0]  eng_rdy;
  logic [2:0]  eng_wren;
  logic [7:0]  eng_addr [3];
  logic [7:0]  eng_data [3];

  int n_cmp = 0;
  int n_bad = 0;
  int mon_cmp = 0;
  int mon_bad = 0;

  arc4_sched dut (
    .clk(clk), .rst(rst), .en(en), .key(key),
    .rdy(rdy), .done(done), .err(err), .key_out(key_out),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren)
  );

  initial forever #5 clk = ~clk;

  assign eng_en = {prga_en, ksa_en, init_en};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      eng_rdy[k]  = !hold_low[k] && (pre[k] != 0 || busy[k] == 0);
      eng_addr[k] = inj[k] ? inj_addr[k] : rnd_addr[k];
      eng_data[k] = inj[k] ? inj_data[k] : rnd_data[k];
      eng_wren[k] = inj[k] | (busy[k] != 0 && rnd_w[k]);
    end
  end

  assign init_rdy = eng_rdy[0];
  assign ksa_rdy  = eng_rdy[1];
  assign prga_rdy = eng_rdy[2];
  assign init_addr = eng_addr[0];
  assign ksa_addr  = eng_addr[1];
  assign prga_addr = eng_addr[2];
  assign init_wrdata = eng_data[0];
  assign ksa_wrdata  = eng_data[1];
  assign prga_wrdata = eng_data[2];
  assign init_wren = eng_wren[0];
  assign ksa_wren  = eng_wren[1];
  assign prga_wren = eng_wren[2];

  // Stub engines: on en, stay ready for dly cycles, then busy for len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        pre[k]  <= 0;
        busy[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (eng_en[k]) begin
          pre[k]  <= dly[k];
          busy[k] <= len[k];
        end else if (pre[k] != 0) pre[k] <= pre[k] - 1;
        else if (busy[k] != 0) busy[k] <= busy[k] - 1;
      end
    end
  end

  // Fresh random addresses, data and write strobes each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rnd_addr[k] = 8'($urandom);
      rnd_data[k] = 8'($urandom);
      rnd_w[k]    = 1'($urandom);
    end
  end

  // Reference model: which engine owns the port, whether it has been launched and seen busy.
  int          m_owner = 0;
  bit          m_launched = 0;
  bit          m_seen = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [23:0] m_key = '0;

  initial forever begin
    logic [2:0]  exp_en;
    logic [16:0] exp_bus;
    bit          conf;
    int          o;
    @(negedge clk);
    if (rst) begin
      m_owner = 0; m_launched = 0; m_seen = 0; m_done = 0; m_err = 0; m_key = '0;
    end else begin
      o = (m_owner == 0) ? 0 : m_owner - 1;
      exp_en = '0;
      exp_bus = '0;
      if (m_owner != 0) begin
        exp_en[o] = !m_launched && eng_rdy[o];
        exp_bus   = {eng_addr[o], eng_data[o], eng_wren[o]};
      end
      conf = 0;
      for (int k = 0; k < 3; k++) if (m_owner != k + 1 && eng_wren[k]) conf = 1;

      mon_cmp++;
      if ({rdy, done, err, eng_en} !== {m_owner == 0, m_done, m_err, exp_en}) begin
        mon_bad++;
        $display("FAIL model.status t=%0t: got rdy/done/err/en=%b want %b", $time,
                 {rdy, done, err, eng_en}, {m_owner == 0, m_done, m_err, exp_en});
      end
      mon_cmp++;
      if (key_out !== m_key) begin
        mon_bad++;
        $display("FAIL model.key_out t=%0t: got %h want %h", $time, key_out, m_key);
      end
      mon_cmp++;
      if ({mem_addr, mem_wrdata, mem_wren} !== exp_bus) begin
        mon_bad++;
        $display("FAIL model.mem t=%0t: got %h want %h", $time,
                 {mem_addr, mem_wrdata, mem_wren}, exp_bus);
      end

      if (en && m_owner == 0) begin
        m_owner = 1; m_launched = 0; m_key = key; m_done = 0; m_err = 0;
      end else begin
        if (conf) m_err = 1;
        if (m_owner != 0) begin
          if (!m_launched) begin
            if (eng_rdy[o]) begin m_launched = 1; m_seen = 0; end
          end else if (!eng_rdy[o]) m_seen = 1;
          else if (m_seen) begin
            m_launched = 0;
            if (m_owner == 3) begin m_owner = 0; m_done = 1; end
            else m_owner = m_owner + 1;
          end
        end
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    @(posedge clk); #1;
    en = 1'b1; key = k;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input logic [23:0] k, output tri_t cnt,
                                output tri_t first, output int cycles, output bit key_ok,
                                output bit ok);
    cnt = '{0, 0, 0}; first = '{-1, -1, -1};
    cycles = 0; key_ok = 1; ok = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) if (eng_en[j]) begin
        cnt[j]++;
        if (first[j] < 0) first[j] = c;
      end
      if (key_out !== k) key_ok = 0;
      if (done) begin cycles = c; ok = 1; break; end
    end
  endtask

  task automatic wait_pulse(input int idx, input int budget, output bit seen);
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (eng_en[idx]) begin seen = 1; break; end
    end
  endtask

  task automatic set_len(input int a, input int b, input int c);
    len = '{a, b, c};
    dly = '{0, 0, 0};
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; key = '0;
    hold_low = '{0, 0, 0}; inj = '{0, 0, 0};
    inj_addr = '{8'h0, 8'h0, 8'h0}; inj_data = '{8'h0, 8'h0, 8'h0};
    set_len(1, 1, 1);
    #1;
    n_cmp++;
    if ({rdy, done, err, eng_en, mem_wren, key_out} !== {3'b100, 3'b000, 1'b0, 24'h0}) begin
      n_bad++;
      $display("FAIL reset.outputs: got %h want %h", {rdy, done, err, eng_en, mem_wren, key_out},
               {3'b100, 3'b000, 1'b0, 24'h0});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_full_run;
    tri_t cnt, first;
    int   cycles;
    bit   key_ok, ok;
    set_len(256, 768, 10);
    start_run(24'h00033C);
    run_until_done(2000, 24'h00033C, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL full_run.timeout: done never rose within 2000 cycles"); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (cnt[j] !== 1) begin n_bad++; $display("FAIL full_run.pulses[%0d]: got %0d want 1", j, cnt[j]); end
    end
    n_cmp++;
    if (!(first[0] < first[1] && first[1] < first[2])) begin
      n_bad++;
      $display("FAIL full_run.order: got cycles %0d,%0d,%0d want increasing", first[0], first[1], first[2]);
    end
    n_cmp++;
    if (key_ok !== 1'b1) begin n_bad++; $display("FAIL full_run.key_stable: key_out moved, want 00033C"); end
    // Each engine costs its busy time + 2; the accept cycle adds 1.
    n_cmp++;
    if (cycles !== 256 + 768 + 10 + 7) begin
      n_bad++;
      $display("FAIL full_run.latency: got %0d want %0d", cycles, 256 + 768 + 10 + 7);
    end
  endtask

  task automatic test_slow_handshake;
    tri_t cnt, first;
    int   cycles;
    bit   key_ok, ok;
    logic [23:0] k;
    k = 24'($urandom);
    set_len(4, 4, 4);
    dly[0] = 3;
    hold_low[0] = 1;
    start_run(k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (init_en !== 1'b0) begin n_bad++; $display("FAIL slow.init_en_held[%0d]: got %b want 0", c, init_en); end
    end
    @(posedge clk); #1;
    hold_low[0] = 0;
    run_until_done(200, k, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if (ok !== 1'b1 || cnt[0] !== 1) begin
      n_bad++; $display("FAIL slow.completion: got ok=%b init pulses=%0d want 1/1", ok, cnt[0]);
    end
    // en, 3 ready cycles, 4 busy, 1 ready-exit, then ksa_en in KSA_GO.
    n_cmp++;
    if (first[1] - first[0] !== 3 + 4 + 2) begin
      n_bad++; $display("FAIL slow.no_early_exit: got gap %0d want 9", first[1] - first[0]);
    end
    dly = '{0, 0, 0};
  endtask

  task automatic test_conflict;
    tri_t cnt, first;
    int   cycles;
    bit   key_ok, ok, seen;
    logic [23:0] k;
    k = 24'($urandom);
    set_len(6, 30, 6);
    start_run(k);
    wait_pulse(1, 100, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL conflict.ksa_start: got none want ksa_en pulse"); end
    repeat (3) @(posedge clk);
    #1;
    inj = '{1, 1, 0};
    inj_addr[0] = 8'h20; inj_data[0] = 8'h55;
    inj_addr[1] = 8'h10; inj_data[1] = 8'hAA;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_wrdata, mem_wren, err} !== {8'h10, 8'hAA, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL conflict.forward: got %h want %h", {mem_addr, mem_wrdata, mem_wren, err},
                        {8'h10, 8'hAA, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    inj = '{0, 0, 0};
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL conflict.err_set: got %b want 1", err); end
    run_until_done(200, k, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if ({ok, err} !== 2'b11) begin n_bad++; $display("FAIL conflict.err_sticky: got ok/err=%b want 11", {ok, err}); end
  endtask

  task automatic test_back_to_back;
    tri_t cnt, first;
    int   cycles;
    bit   key_ok, ok;
    logic [23:0] k;
    k = 24'($urandom);
    set_len(5, 12, 7);
    start_run(k);
    @(negedge clk);
    n_cmp++;
    if ({done, err, rdy, init_en, key_out} !== {4'b0001, k}) begin
      n_bad++; $display("FAIL b2b.restart: got %h want %h", {done, err, rdy, init_en, key_out}, {4'b0001, k});
    end
    run_until_done(200, k, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if ({ok, key_ok, err} !== 3'b110 || cnt[1] !== 1 || cnt[2] !== 1) begin
      n_bad++; $display("FAIL b2b.second_run: got ok/key_ok/err=%b ksa=%0d prga=%0d want 110 1 1",
                        {ok, key_ok, err}, cnt[1], cnt[2]);
    end
  endtask

  task automatic test_busy_start;
    tri_t cnt, first;
    int   cycles, extra;
    bit   key_ok, ok, seen;
    logic [23:0] k1, k2;
    k1 = 24'($urandom);
    k2 = ~k1;
    set_len(4, 4, 20);
    start_run(k1);
    wait_pulse(2, 100, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL busy.prga_start: got none want prga_en pulse"); end
    @(posedge clk); #1;
    en = 1'b1; key = k2;
    @(posedge clk); #1;
    en = 1'b0; key = k1;
    run_until_done(200, k1, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if ({ok, key_ok} !== 2'b11 || cnt[0] !== 0 || cnt[1] !== 0) begin
      n_bad++; $display("FAIL busy.ignored: got ok/key_ok=%b init=%0d ksa=%0d want 11 0 0",
                        {ok, key_ok}, cnt[0], cnt[1]);
    end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (init_en || !done) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL busy.single_completion: got %0d bad cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_ksa;
    tri_t cnt, first;
    int   cycles;
    bit   key_ok, ok, seen;
    logic [23:0] k;
    k = 24'($urandom);
    set_len(4, 50, 4);
    start_run(k);
    wait_pulse(1, 100, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_ksa.ksa_start: got none want ksa_en pulse"); end
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy, done, err, eng_en, mem_wren, mem_addr, key_out} !== {3'b100, 4'b0, 8'h0, 24'h0}) begin
      n_bad++; $display("FAIL rst_ksa.async: got %h want %h", {rdy, done, err, eng_en, mem_wren, mem_addr, key_out},
                        {3'b100, 4'b0, 8'h0, 24'h0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    k = 24'($urandom);
    start_run(k);
    @(negedge clk);
    n_cmp++;
    if ({init_en, ksa_en, prga_en} !== 3'b100) begin
      n_bad++; $display("FAIL rst_ksa.restart: got init/ksa/prga=%b want 100", {init_en, ksa_en, prga_en});
    end
    run_until_done(200, k, cnt, first, cycles, key_ok, ok);
    n_cmp++;
    if (ok !== 1'b1 || cnt[1] !== 1 || cnt[2] !== 1) begin
      n_bad++; $display("FAIL rst_ksa.complete: got ok=%b ksa=%0d prga=%0d want 1 1 1", ok, cnt[1], cnt[2]);
    end
  endtask

  task automatic test_random;
    tri_t cnt, first;
    int   cycles, want;
    bit   key_ok, ok;
    logic [23:0] k;
    for (int r = 0; r < 6; r++) begin
      want = 7;
      for (int j = 0; j < 3; j++) begin
        len[j] = $urandom_range(1, 40);
        dly[j] = $urandom_range(0, 3);
        want += len[j] + dly[j];
      end
      k = 24'($urandom);
      start_run(k);
      run_until_done(500, k, cnt, first, cycles, key_ok, ok);
      n_cmp++;
      if ({ok, key_ok} !== 2'b11 || cnt[0] !== 1 || cnt[1] !== 1 || cnt[2] !== 1 || cycles !== want) begin
        n_bad++; $display("FAIL random[%0d]: got ok/key_ok=%b pulses=%0d%0d%0d cycles=%0d want 11 111 %0d",
                          r, {ok, key_ok}, cnt[0], cnt[1], cnt[2], cycles, want);
      end
    end
    dly = '{0, 0, 0};
  endtask

  task automatic test_scoreboard;
    n_cmp++;
    if (mon_bad !== 0 || mon_cmp < 300) begin
      n_bad++; $display("FAIL scoreboard: got %0d bad of %0d cycle checks want 0 of >=300", mon_bad, mon_cmp);
    end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_slow_handshake;
    test_conflict;
    test_back_to_back;
    test_busy_start;
    test_reset_mid_ksa;
    test_random;
    repeat (2) @(negedge clk);
    test_scoreboard;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
